instr_mem_loader: RTL and testbench

Instruction-memory subsystem directly upstream of the core's instruction fetch port. At boot it receives a program as a byte stream through a valid/ready handshake, for example from a UART receiver. It writes that program into an internal instruction RAM and holds the core in reset until loading is complete. It then serves fetches with 1-cycle synchronous-read latency and honours the core's fetch enable (stall) and flush signals.

---
 rtl/instr_mem_loader.sv | 121 ++++++++++++
 tb/tb_instr_mem_loader.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_loader.sv
// Boot-time program loader and instruction RAM: receives a length-prefixed byte stream,
// holds the core in reset until the program is written, then serves 1-cycle fetches.
module instr_mem_loader #(
  parameter int          ADDR_WIDTH = 10,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  core_reset,
  output logic                  load_done,
  output logic                  load_error,
  output logic [ADDR_WIDTH:0]   words_loaded,
  input  logic [31:0]           instr_memory_addr,
  input  logic                  instr_memory_enable,
  input  logic                  instr_memory_flush,
  output logic [31:0]           instr_memory_data
);

  localparam int         DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [16:0] DEPTH_LEN = 17'(DEPTH);

  typedef enum logic [2:0] {LEN_LO, LEN_HI, DATA, RUN, ERR} state_t;

  state_t                state, next_state;
  logic [1:0]            byte_cnt;
  logic [15:0]           len;
  logic [23:0]           word_buf;
  logic [31:0]           ram [DEPTH];

  logic                  accept;
  logic                  word_done;
  logic [15:0]           full_len;
  logic [16:0]           words_next;
  logic [ADDR_WIDTH-1:0] widx;
  logic                  in_range;
  logic                  unused_addr_bits;

  assign rx_ready   = (state == LEN_LO) || (state == LEN_HI) || (state == DATA);
  assign load_done  = (state == RUN);
  assign load_error = (state == ERR);
  assign accept     = rx_valid && rx_ready;
  assign word_done  = accept && (state == DATA) && (byte_cnt == 2'd3);
  assign full_len   = {rx_data, len[7:0]};
  assign words_next = 17'(words_loaded) + 17'd1;

  // NOTE: next_state gets its default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    next_state = state;
    case (state)
      LEN_LO: if (accept) next_state = LEN_HI;
      LEN_HI: begin
        if (accept) begin
          if (full_len == 16'd0)                  next_state = RUN;
          else if ({1'b0, full_len} > DEPTH_LEN)  next_state = ERR;
          else                                    next_state = DATA;
        end
      end
      DATA: if (word_done && (words_next == {1'b0, len})) next_state = RUN;
      default: ;
    endcase
  end

  // NOTE: all state registers use non-blocking assignments so every update sees pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= LEN_LO;
      byte_cnt     <= '0;
      len          <= '0;
      word_buf     <= '0;
      words_loaded <= '0;
      core_reset   <= 1'b1;
    end else begin
      state      <= next_state;
      core_reset <= (next_state != RUN);
      if (accept) begin
        case (state)
          LEN_LO: len[7:0]  <= rx_data;
          LEN_HI: len[15:8] <= rx_data;
          DATA: begin
            byte_cnt <= byte_cnt + 2'd1;
            case (byte_cnt)
              2'd0:    word_buf[7:0]   <= rx_data;
              2'd1:    word_buf[15:8]  <= rx_data;
              2'd2:    word_buf[23:16] <= rx_data;
              default: ;
            endcase
          end
          default: ;
        endcase
      end
      if (word_done) words_loaded <= words_next[ADDR_WIDTH:0];
    end
  end

  // NOTE: the RAM has no reset; stale words are hidden because fetches are bounded by words_loaded.
  always_ff @(posedge clk) begin
    if (word_done) ram[words_loaded[ADDR_WIDTH-1:0]] <= {rx_data, word_buf};
  end

  assign widx             = instr_memory_addr[ADDR_WIDTH+1:2];
  assign in_range         = (instr_memory_addr[31:ADDR_WIDTH+2] == '0) &&
                            ({1'b0, widx} < words_loaded);
  assign unused_addr_bits = ^instr_memory_addr[1:0];

  // Flush outranks enable; with neither, the register holds so a stalled IF stage keeps its word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_memory_data <= NOP_INSTR;
    end else if (state != RUN) begin
      instr_memory_data <= NOP_INSTR;
    end else if (instr_memory_flush) begin
      instr_memory_data <= NOP_INSTR;
    end else if (instr_memory_enable) begin
      instr_memory_data <= in_range ? ram[widx] : NOP_INSTR;
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Scoreboard bench for instr_mem_loader: a driver pushes predicted fetch words, a monitor
// pops and compares them one cycle later; loader status is checked directly by the driver.
module tb_instr_mem_loader;

  localparam int          AW    = 10;
  localparam int          DEPTH = 1 << AW;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        core_reset;
  logic        load_done;
  logic        load_error;
  logic [AW:0] words_loaded;
  logic [31:0] instr_memory_addr = '0;
  logic        instr_memory_enable = 1'b0;
  logic        instr_memory_flush = 1'b0;
  logic [31:0] instr_memory_data;

  instr_mem_loader #(.ADDR_WIDTH(AW), .NOP_INSTR(NOP)) dut (
    .clk                 (clk),
    .reset               (reset),
    .rx_data             (rx_data),
    .rx_valid            (rx_valid),
    .rx_ready            (rx_ready),
    .core_reset          (core_reset),
    .load_done           (load_done),
    .load_error          (load_error),
    .words_loaded        (words_loaded),
    .instr_memory_addr   (instr_memory_addr),
    .instr_memory_enable (instr_memory_enable),
    .instr_memory_flush  (instr_memory_flush),
    .instr_memory_data   (instr_memory_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] exp;
    string       tag;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          n_checks = 0;
  int          n_errors = 0;

  // Reference model: the loaded program as a plain word list plus the fetch output register.
  logic [31:0] prog_q[$];
  logic [31:0] mdl_mem[$];
  int unsigned mdl_words;
  bit          mdl_run;
  logic [31:0] mdl_data;
  logic [7:0]  stream_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        mon_e = sb_q.pop_front();
        check(mon_e.tag, instr_memory_data, mon_e.exp);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", n_errors, n_checks);
    $fatal(1, "watchdog expired");
  end

  function automatic void build_stream();
    int unsigned n;
    n = prog_q.size();
    stream_q.delete();
    stream_q.push_back(8'(n % 256));
    stream_q.push_back(8'(n / 256));
    foreach (prog_q[i])
      for (int k = 0; k < 4; k++) stream_q.push_back(8'((prog_q[i] >> (8 * k)) & 32'hFF));
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    rx_valid = 1'b0;
    instr_memory_enable = 1'b0;
    instr_memory_flush = 1'b0;
    mdl_run = 1'b0;
    mdl_words = 0;
    mdl_data = NOP;
    mdl_mem.delete();
    #1;
    check("reset_words_loaded", 32'(words_loaded), 32'd0);
    check("reset_core_reset", 32'(core_reset), 32'd1);
    check("reset_load_done", 32'(load_done), 32'd0);
    check("reset_load_error", 32'(load_error), 32'd0);
    check("reset_data", instr_memory_data, NOP);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    check("reset_rx_ready", 32'(rx_ready), 32'd1);
  endtask

  // Offers one byte (after optional random bubbles) and returns #1 after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input int gap_pct);
    int gaps;
    int waited;
    @(negedge clk);
    gaps = ($urandom_range(0, 99) < gap_pct) ? int'($urandom_range(1, 3)) : 0;
    for (int g = 0; g < gaps; g++) begin
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
      @(negedge clk);
    end
    rx_valid = 1'b1;
    rx_data  = b;
    waited = 0;
    while (!rx_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!rx_ready) begin
      check("rx_ready_timeout", 32'(rx_ready), 32'd1);
      rx_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
    end
  endtask

  task automatic send_stream(input int gap_pct, input int n_bytes);
    for (int i = 0; i < n_bytes; i++) begin
      send_byte(stream_q[i], gap_pct);
      if (i < stream_q.size() - 1) check("core_reset_while_loading", 32'(core_reset), 32'd1);
    end
  endtask

  task automatic complete_load();
    check("load_done_at_last_byte", 32'(load_done), 32'd1);
    check("core_reset_at_last_byte", 32'(core_reset), 32'd0);
    check("rx_ready_in_run", 32'(rx_ready), 32'd0);
    check("words_loaded_final", 32'(words_loaded), prog_q.size());
    mdl_mem   = prog_q;
    mdl_words = prog_q.size();
    mdl_run   = 1'b1;
  endtask

  task automatic fetch(input logic [31:0] addr, input logic en, input logic fl, input string tag,
                       input bit use_const = 1'b0, input logic [31:0] cval = '0);
    exp_t        e;
    logic [31:0] idx;
    @(negedge clk);
    instr_memory_addr   = addr;
    instr_memory_enable = en;
    instr_memory_flush  = fl;
    idx = addr >> 2;
    if (!mdl_run || fl) mdl_data = NOP;
    else if (en)        mdl_data = (idx < mdl_words) ? mdl_mem[idx] : NOP;
    e.exp = use_const ? cval : mdl_data;
    e.tag = tag;
    sb_q.push_back(e);
  endtask

  task automatic fetch_end();
    @(negedge clk);
    instr_memory_enable = 1'b0;
    instr_memory_flush  = 1'b0;
    @(posedge clk);
    #2;
    check("scoreboard_drained", sb_q.size(), 32'd0);
  endtask

  task automatic rand_fetch(input int n);
    int          r;
    logic [31:0] addr;
    for (int i = 0; i < n; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 75)      addr = $urandom_range(0, 4 * mdl_words + 15);
      else if (r < 90) addr = $urandom;
      else             addr = 32'h1000_0000 | $urandom_range(0, 63);
      fetch(addr, $urandom_range(0, 99) < 75, $urandom_range(0, 99) < 15, "rand_fetch");
    end
  endtask

  task automatic plan_fetches();
    fetch(32'h0,         1'b1, 1'b0, "t1_addr0",    1'b1, 32'h0010_0513);
    fetch(32'h8,         1'b1, 1'b0, "t1_addr8",    1'b1, 32'h00B5_0633);
    fetch(32'hC,         1'b1, 1'b0, "t1_addrC",    1'b1, NOP);
    fetch(32'h1000_0000, 1'b1, 1'b0, "t4_high_addr", 1'b1, NOP);
    fetch(32'h4,         1'b1, 1'b0, "t2_fetch4",   1'b1, 32'h0020_0593);
    repeat (3) fetch(32'h0, 1'b0, 1'b0, "t2_stall", 1'b1, 32'h0020_0593);
    fetch(32'h0,         1'b1, 1'b1, "t3_flush",    1'b1, NOP);
    fetch(32'h0,         1'b1, 1'b0, "t3_after",    1'b1, 32'h0010_0513);
    fetch_end();
  endtask

  initial begin
    mdl_data = NOP;

    // Test plan items 1-3: straight-through load, directed fetch/stall/flush, then random fetches.
    prog_q = '{32'h0010_0513, 32'h0020_0593, 32'h00B5_0633};
    build_stream();
    apply_reset();
    send_stream(0, stream_q.size());
    complete_load();
    plan_fetches();
    rand_fetch(80);
    fetch_end();

    // Zero-length program goes straight to RUN with nothing fetchable.
    prog_q.delete();
    build_stream();
    apply_reset();
    send_stream(0, stream_q.size());
    complete_load();
    rand_fetch(30);
    fetch_end();

    // Oversize length is terminal and keeps the core in reset.
    apply_reset();
    stream_q = '{8'h01, 8'h04};
    send_stream(0, 2);
    check("oversize_load_error", 32'(load_error), 32'd1);
    check("oversize_rx_ready", 32'(rx_ready), 32'd0);
    check("oversize_load_done", 32'(load_done), 32'd0);
    repeat (20) begin
      fetch($urandom_range(0, 63), 1'b1, $urandom_range(0, 1) == 1, "oversize_fetch");
      check("oversize_core_reset", 32'(core_reset), 32'd1);
    end
    fetch_end();

    // Bubbled stream, then a reset after 6 bytes and a full reload.
    prog_q = '{32'h0010_0513, 32'h0020_0593, 32'h00B5_0633};
    build_stream();
    apply_reset();
    send_stream(50, stream_q.size());
    complete_load();
    plan_fetches();
    apply_reset();
    send_stream(30, 6);
    apply_reset();
    send_stream(30, stream_q.size());
    complete_load();
    plan_fetches();

    // Random programs with random bubbles.
    repeat (3) begin
      prog_q.delete();
      repeat ($urandom_range(1, 20)) prog_q.push_back($urandom);
      build_stream();
      apply_reset();
      send_stream(30, stream_q.size());
      complete_load();
      rand_fetch(100);
      fetch_end();
    end

    // Length exactly DEPTH fills the RAM; last word and one-past-end are the edges.
    prog_q.delete();
    repeat (DEPTH) prog_q.push_back($urandom);
    build_stream();
    apply_reset();
    send_stream(0, stream_q.size());
    complete_load();
    fetch(32'(4 * (DEPTH - 1)), 1'b1, 1'b0, "full_last_word");
    fetch(32'(4 * DEPTH),       1'b1, 1'b0, "full_past_end", 1'b1, NOP);
    rand_fetch(60);
    fetch_end();

    // Short reload after a full RAM: stale words beyond the new length must stay hidden.
    prog_q = '{$urandom, $urandom};
    build_stream();
    apply_reset();
    send_stream(20, stream_q.size());
    complete_load();
    fetch(32'h8,  1'b1, 1'b0, "stale_word2", 1'b1, NOP);
    fetch(32'h40, 1'b1, 1'b0, "stale_word16", 1'b1, NOP);
    fetch(32'h4,  1'b1, 1'b0, "reload_word1");
    rand_fetch(40);
    fetch_end();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
